// File: rtl/dccm_arb_pkg.sv
// rtl/dccm_arb_pkg.sv - shared types and constants for the DCCM port arbiter
package dccm_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_LSU, OWN_DMA} owner_e;

  typedef enum logic {LSU_PRI, DMA_FORCE} arb_state_e;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/dccm_arb_sat_cnt.sv
// rtl/dccm_arb_sat_cnt.sv - saturating up-counter with synchronous clear
module dccm_arb_sat_cnt #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dccm_port_arb.sv
// rtl/dccm_port_arb.sv - LSU/DMA arbiter for the single DCCM port (optional DCCM_PORT_ARB_PERF_EN grant counters)
module dccm_port_arb
  import dccm_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FDATA_W    = 72,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic               lsu_req_wr,
  input  logic [ADDR_W-1:0]  lsu_req_addr,
  input  logic [FDATA_W-1:0] lsu_req_wdata,
  output logic               lsu_rsp_valid,
  output logic [FDATA_W-1:0] lsu_rsp_rdata,
  input  logic               dma_req_valid,
  output logic               dma_req_ready,
  input  logic               dma_req_wr,
  input  logic [ADDR_W-1:0]  dma_req_addr,
  input  logic [FDATA_W-1:0] dma_req_wdata,
  output logic               dma_rsp_valid,
  output logic [FDATA_W-1:0] dma_rsp_rdata,
  output logic               dccm_rden,
  output logic               dccm_wren,
  output logic [ADDR_W-1:0]  dccm_addr,
  output logic [FDATA_W-1:0] dccm_wr_data,
  input  logic [FDATA_W-1:0] dccm_rd_data,
  output logic               dma_forced
`ifdef DCCM_PORT_ARB_PERF_EN
  ,
  output logic [15:0]        perf_lsu_grants,
  output logic [15:0]        perf_dma_grants,
  output logic [15:0]        perf_forced_grants
`endif
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX_C  = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] STARVE_LAST_C = STARVE_CNT_W'(STARVE_MAX - 1);

  arb_state_e              state;
  owner_e                  rsp_owner;
  logic                    grant_lsu;
  logic                    grant_dma;
  logic                    lsu_fire;
  logic                    dma_fire;
  logic                    starve_inc;
  logic                    starve_clr;
  logic                    force_next;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  // Grant is held off during reset so every request-side output reads 0.
  always_comb begin
    grant_lsu = 1'b0;
    grant_dma = 1'b0;
    if (!rst) begin
      if (state == LSU_PRI) begin
        if (lsu_req_valid)      grant_lsu = 1'b1;
        else if (dma_req_valid) grant_dma = 1'b1;
      end else begin
        if (dma_req_valid)      grant_dma = 1'b1;
        else if (lsu_req_valid) grant_lsu = 1'b1;
      end
    end
  end

  assign lsu_req_ready = grant_lsu & lsu_req_valid;
  assign dma_req_ready = grant_dma & dma_req_valid;
  assign lsu_fire      = lsu_req_ready;
  assign dma_fire      = dma_req_ready;

  always_comb begin
    dccm_rden    = 1'b0;
    dccm_wren    = 1'b0;
    dccm_addr    = '0;
    dccm_wr_data = '0;
    if (lsu_fire) begin
      dccm_rden    = ~lsu_req_wr;
      dccm_wren    = lsu_req_wr;
      dccm_addr    = lsu_req_addr;
      dccm_wr_data = lsu_req_wdata;
    end else if (dma_fire) begin
      dccm_rden    = ~dma_req_wr;
      dccm_wren    = dma_req_wr;
      dccm_addr    = dma_req_addr;
      dccm_wr_data = dma_req_wdata;
    end
  end

  assign starve_inc = dma_req_valid & ~dma_req_ready;
  assign starve_clr = dma_fire | ~dma_req_valid;

  dccm_arb_sat_cnt #(
    .WIDTH (STARVE_CNT_W),
    .MAX   (STARVE_MAX_C)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .count (starve_cnt)
  );

  // Leaving DMA_FORCE always clears the counter, so in LSU_PRI it sits below
  // the limit and hitting the limit next cycle means it is one short now.
  assign force_next = starve_inc & (starve_cnt == STARVE_LAST_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LSU_PRI;
    end else begin
      case (state)
        LSU_PRI:   if (force_next) state <= DMA_FORCE;
        DMA_FORCE: if (dma_fire || !dma_req_valid) state <= LSU_PRI;
        default:   state <= LSU_PRI;
      endcase
    end
  end

  assign dma_forced = (state == DMA_FORCE) & dma_fire;

  always_ff @(posedge clk) begin
    if (rst)            rsp_owner <= OWN_NONE;
    else if (dccm_rden) rsp_owner <= lsu_fire ? OWN_LSU : OWN_DMA;
    else                rsp_owner <= OWN_NONE;
  end

  // A read issued just before reset must not surface while reset is high.
  assign lsu_rsp_valid = (rsp_owner == OWN_LSU) & ~rst;
  assign dma_rsp_valid = (rsp_owner == OWN_DMA) & ~rst;
  assign lsu_rsp_rdata = lsu_rsp_valid ? dccm_rd_data : '0;
  assign dma_rsp_rdata = dma_rsp_valid ? dccm_rd_data : '0;

`ifdef DCCM_PORT_ARB_PERF_EN
  dccm_arb_sat_cnt #(.WIDTH(16), .MAX(16'hFFFF)) u_perf_lsu (
    .clk (clk), .rst (rst), .inc (lsu_fire), .clr (1'b0), .count (perf_lsu_grants)
  );

  dccm_arb_sat_cnt #(.WIDTH(16), .MAX(16'hFFFF)) u_perf_dma (
    .clk (clk), .rst (rst), .inc (dma_fire), .clr (1'b0), .count (perf_dma_grants)
  );

  dccm_arb_sat_cnt #(.WIDTH(16), .MAX(16'hFFFF)) u_perf_forced (
    .clk (clk), .rst (rst), .inc (dma_forced), .clr (1'b0), .count (perf_forced_grants)
  );
`endif

endmodule

// File: doc/dccm_port_arb.md
Name: dccm_port_arb

Overview:
- Arbitrates the single DCCM read/write port between the LSU pipeline and the DMA slave.
- Sits between lsu/dma request logic and the DCCM macro. Routes the one-cycle-latency read data back to whichever requester owns it.
- LSU has fixed priority, except that a starvation counter forces a DMA grant after STARVE_MAX consecutive lost cycles.

Parameters:
- ADDR_W, 16, DCCM byte address width (matches RV_DCCM_BITS)
- FDATA_W, 72, DCCM data+ECC width (64 data + 8 ECC)
- STARVE_MAX, 4, consecutive DMA-pending-not-granted cycles before a DMA grant is forced; legal 1..15

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- lsu_req_valid  in  1  LSU request valid; held stable until ready
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wr  in  1  1=write, 0=read
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wdata  in  FDATA_W  LSU write data
- lsu_rsp_valid  out  1  LSU read data valid
- lsu_rsp_rdata  out  FDATA_W  LSU read data
- dma_req_valid, dma_req_ready, dma_req_wr, dma_req_addr, dma_req_wdata  same widths/directions as the LSU request ports
- dma_rsp_valid  out  1  DMA read data valid
- dma_rsp_rdata  out  FDATA_W  DMA read data
- dccm_rden  out  1  DCCM read enable
- dccm_wren  out  1  DCCM write enable
- dccm_addr  out  ADDR_W  DCCM address
- dccm_wr_data  out  FDATA_W  DCCM write data
- dccm_rd_data  in  FDATA_W  DCCM read data; valid the cycle after dccm_rden
- dma_forced  out  1  current grant is a starvation-forced DMA grant

Behaviour:
- Reset: all outputs 0. starve_cnt=0, state=LSU_PRI, rsp owner flops cleared. Reset mid-read drops the pending response: no rsp_valid in the cycle after reset.
- Grant is combinational in cycle N:
  - state LSU_PRI: lsu_req_valid -> grant LSU; otherwise dma_req_valid -> grant DMA.
  - state DMA_FORCE: dma_req_valid -> grant DMA; otherwise LSU.
- At most one ready per cycle. ready = valid & granted. A fire is valid&ready.
- DCCM drive in cycle N from the winner: rden = fire & ~wr; wren = fire & wr. addr and wr_data come from the winner. With no fire: enables 0, addr/wr_data 0.
- Response: a read fire in N sets <owner>_rsp_valid=1 in N+1 (flopped). <owner>_rsp_rdata = dccm_rd_data in N+1, zero otherwise. Writes produce no response.
- Back-to-back reads by alternating owners must each return to the correct owner.
- Starvation counter (4 bits):
  - Increments when dma_req_valid & ~dma_req_ready.
  - Clears on a DMA fire or when dma_req_valid=0.
  - Saturates at STARVE_MAX.
- State machine:
  - LSU_PRI -> DMA_FORCE when the next starve_cnt == STARVE_MAX.
  - DMA_FORCE -> LSU_PRI after one DMA fire, or when dma_req_valid drops.
- dma_forced = (state==DMA_FORCE) & dma fire.
- Simultaneous requests with starve_cnt below threshold: LSU wins, counter increments.
- Requester dropping valid before ready is illegal; no recovery is required.

Optional Feature:
- Macro DCCM_PORT_ARB_PERF_EN.
- Defined: adds output ports perf_lsu_grants[15:0], perf_dma_grants[15:0], perf_forced_grants[15:0].
  - Each is a saturating counter (stops at 16'hFFFF) incremented on the matching fire.
  - Cleared by rst.
- Undefined: ports and counters absent. All other behaviour is identical.

Decomposition:
- Package dccm_arb_pkg holds:
  - typedef enum owner_e {OWN_NONE, OWN_LSU, OWN_DMA}
  - typedef enum arb_state_e {LSU_PRI, DMA_FORCE}
  - localparam STARVE_CNT_W=4
- Sub-module dccm_arb_sat_cnt: parameterised width, inc/clear, saturating. Used for starve_cnt and the perf counters.

Test Plan:
- Reset held 3 cycles with both valids high -> both ready=0, dccm_rden/wren=0, rsp_valid=0 throughout.
- LSU read only, addr 16'h0040, stub returns 72'h00_DEAD_BEEF_0000_0001 -> lsu_req_ready=1 in N, lsu_rsp_valid=1 in N+1 with that data, dma_rsp_valid=0.
- LSU and DMA reads both valid continuously, STARVE_MAX=4 -> LSU granted 4 cycles, DMA granted cycle 5 with dma_forced=1, then LSU resumes; pattern repeats.
- LSU read N, DMA read N+1 (LSU idle) -> lsu_rsp_valid at N+1, dma_rsp_valid at N+2, no cross-routing.
- DMA write addr 16'h0008 data 72'h11_2233_4455_6677_8899 -> dccm_wren=1, dccm_addr=16'h0008, no rsp_valid in N+1.
- Reset asserted the cycle after an LSU read fire -> lsu_rsp_valid stays 0; with DCCM_PORT_ARB_PERF_EN defined, perf_lsu_grants reads 0.
